data_island_rx: RTL and testbench

DATA_ISLAND_RX -- requirements
Module: data_island_rx

---
 rtl/hdmi_data_island_pkg.sv | 16 +
 rtl/bch_lfsr.sv | 35 +++
 rtl/data_island_rx.sv | 131 +++++++++++++
 tb/tb_data_island_rx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_data_island_pkg.sv
// Shared constants and the BCH parity step for the HDMI data-island receive path.
package hdmi_data_island_pkg;

   localparam int PACKET_SYMBOLS = 32;
   localparam int HEADER_BITS    = 24;
   localparam int SUB_BITS       = 56;
   localparam int NUM_SUBS       = 4;
   localparam int PARITY_BITS    = 8;
   localparam logic [7:0] BCH_POLY = 8'h83;

   // One LSB-first step of the BCH parity LFSR.
   function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic bit_in);
      return (ecc >> 1) ^ ((ecc[0] ^ bit_in) ? BCH_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/bch_lfsr.sv
// One lane's BCH parity LFSR, consuming BITS_PER_CYCLE message bits per enabled
// cycle with bits[0] first.
module bch_lfsr
   import hdmi_data_island_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      clk_pixel,
   input  logic                      reset_n,
   input  logic                      clear,
   input  logic                      shift,
   input  logic [BITS_PER_CYCLE-1:0] bits,
   output logic [PARITY_BITS-1:0]    ecc
);

   logic [PARITY_BITS-1:0] ecc_next;

   always_comb begin
      ecc_next = ecc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         ecc_next = bch_step(ecc_next, bits[i]);
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         ecc <= '0;
      end else if (clear) begin
         ecc <= '0;
      end else if (shift) begin
         ecc <= ecc_next;
      end
   end

endmodule

// File: rtl/data_island_rx.sv
// HDMI data-island packet receiver: assembles 32 symbols into header and four
// subpackets. Parity checking is built only when DATA_ISLAND_RX_ECC_EN is defined.
module data_island_rx
   import hdmi_data_island_pkg::*;
(
   input  logic                   clk_pixel,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [8:0]             data,
   output logic [HEADER_BITS-1:0] header,
   output logic [SUB_BITS-1:0]    sub0,
   output logic [SUB_BITS-1:0]    sub1,
   output logic [SUB_BITS-1:0]    sub2,
   output logic [SUB_BITS-1:0]    sub3,
   output logic                   packet_valid,
   output logic [4:0]             ecc_error
);

   logic [4:0]             k;
   logic [HEADER_BITS-1:0] hdr_acc;
   logic [SUB_BITS-1:0]    sub_acc [NUM_SUBS];
   logic                   last_sym;
   logic                   hdr_data_phase;
   logic                   sub_data_phase;
   logic [4:0]             ecc_error_next;

   assign last_sym       = enable && (k == 5'(PACKET_SYMBOLS - 1));
   assign hdr_data_phase = (k < 5'(HEADER_BITS));
   assign sub_data_phase = (k < 5'(SUB_BITS / 2));

   // Data positions are written directly by symbol index; every position is
   // rewritten by each complete packet, so an aborted packet leaves nothing behind.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         k            <= '0;
         hdr_acc      <= '0;
         header       <= '0;
         sub0         <= '0;
         sub1         <= '0;
         sub2         <= '0;
         sub3         <= '0;
         ecc_error    <= '0;
         packet_valid <= 1'b0;
         for (int i = 0; i < NUM_SUBS; i++) begin
            sub_acc[i] <= '0;
         end
      end else begin
         packet_valid <= last_sym;
         k            <= enable ? k + 5'd1 : 5'd0;
         if (enable && hdr_data_phase) begin
            hdr_acc[k] <= data[0];
         end
         if (enable && sub_data_phase) begin
            for (int i = 0; i < NUM_SUBS; i++) begin
               sub_acc[i][{k, 1'b0}] <= data[1+i];
               sub_acc[i][{k, 1'b1}] <= data[5+i];
            end
         end
         if (last_sym) begin
            header    <= hdr_acc;
            sub0      <= sub_acc[0];
            sub1      <= sub_acc[1];
            sub2      <= sub_acc[2];
            sub3      <= sub_acc[3];
            ecc_error <= ecc_error_next;
         end
      end
   end

`ifdef DATA_ISLAND_RX_ECC_EN
   logic [PARITY_BITS-1:0] hdr_par;
   logic [PARITY_BITS-1:0] sub_par [NUM_SUBS];
   logic [PARITY_BITS-1:0] hdr_ecc;
   logic [PARITY_BITS-1:0] sub_ecc [NUM_SUBS];
   logic                   lfsr_clear;

   // Re-seed between packets and whenever the symbol stream is interrupted.
   assign lfsr_clear = !enable || last_sym;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         hdr_par <= '0;
         for (int i = 0; i < NUM_SUBS; i++) begin
            sub_par[i] <= '0;
         end
      end else if (enable) begin
         if (!hdr_data_phase) begin
            hdr_par[k[2:0]] <= data[0];
         end
         if (!sub_data_phase) begin
            for (int i = 0; i < NUM_SUBS; i++) begin
               sub_par[i][{k[1:0], 1'b0}] <= data[1+i];
               sub_par[i][{k[1:0], 1'b1}] <= data[5+i];
            end
         end
      end
   end

   bch_lfsr #(.BITS_PER_CYCLE(1)) u_hdr_lfsr (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clear     (lfsr_clear),
      .shift     (enable && hdr_data_phase),
      .bits      (data[0]),
      .ecc       (hdr_ecc)
   );

   for (genvar g = 0; g < NUM_SUBS; g++) begin : g_sub_lfsr
      bch_lfsr #(.BITS_PER_CYCLE(2)) u_sub_lfsr (
         .clk_pixel (clk_pixel),
         .reset_n   (reset_n),
         .clear     (lfsr_clear),
         .shift     (enable && sub_data_phase),
         .bits      ({data[5+g], data[1+g]}),
         .ecc       (sub_ecc[g])
      );
   end

   // The final parity bits arrive with the last symbol, so merge them in here.
   always_comb begin
      ecc_error_next    = '0;
      ecc_error_next[4] = (hdr_ecc != {data[0], hdr_par[6:0]});
      for (int i = 0; i < NUM_SUBS; i++) begin
         ecc_error_next[i] = (sub_ecc[i] != {data[5+i], data[1+i], sub_par[i][5:0]});
      end
   end
`else
   assign ecc_error_next = '0;
`endif

endmodule

// File: tb/tb_data_island_rx.sv
// Self-checking bench for data_island_rx against a packet-level encoder model.
module tb_data_island_rx;

   localparam int W = 253;

   logic        clk_pixel = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [8:0]  data;
   logic [23:0] header;
   logic [55:0] sub0, sub1, sub2, sub3;
   logic        packet_valid;
   logic [4:0]  ecc_error;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int           obs_cyc_q[$];

   // Transmitted packet: data bits then 8 parity bits per lane.
   logic [31:0] hbits;
   logic [63:0] sbits [4];

   data_island_rx dut (
      .clk_pixel    (clk_pixel),
      .reset_n      (reset_n),
      .enable       (enable),
      .data         (data),
      .header       (header),
      .sub0         (sub0),
      .sub1         (sub1),
      .sub2         (sub2),
      .sub3         (sub3),
      .packet_valid (packet_valid),
      .ecc_error    (ecc_error)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_pixel = ~clk_pixel;
   always @(posedge clk_pixel) cycle <= cycle + 1;

   always @(negedge clk_pixel) begin
      if (packet_valid === 1'b1) begin
         obs_q.push_back({header, sub3, sub2, sub1, sub0, ecc_error});
         obs_cyc_q.push_back(cycle);
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] bch(input logic [63:0] msg, input int n);
      logic [7:0] e = 8'h00;
      for (int i = 0; i < n; i++) begin
         e = (e >> 1) ^ ((e[0] ^ msg[i]) ? 8'h83 : 8'h00);
      end
      return e;
   endfunction

   task automatic load(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                       input logic [55:0] s2, input logic [55:0] s3);
      logic [55:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      hbits = {bch({40'd0, h}, 24), h};
      for (int i = 0; i < 4; i++) sbits[i] = {bch({8'd0, s[i]}, 56), s[i]};
   endtask

   task automatic load_random();
      load(24'($urandom()), 56'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}),
           56'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}));
   endtask

   function automatic logic [W-1:0] expected();
      logic [4:0] ee = 5'b0;
`ifdef DATA_ISLAND_RX_ECC_EN
      ee[4] = (bch({32'd0, hbits}, 24) != hbits[31:24]);
      for (int i = 0; i < 4; i++) ee[i] = (bch(sbits[i], 56) != sbits[i][63:56]);
`endif
      return {hbits[23:0], sbits[3][55:0], sbits[2][55:0], sbits[1][55:0], sbits[0][55:0], ee};
   endfunction

   function automatic logic [8:0] symbol(input int k);
      logic [8:0] d;
      d[0] = hbits[k];
      for (int i = 0; i < 4; i++) begin
         d[1+i] = sbits[i][2*k];
         d[5+i] = sbits[i][2*k+1];
      end
      return d;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_symbols(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_pixel);
         enable = 1'b1;
         data   = symbol(k);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_pixel);
         enable = 1'b0;
         data   = 9'($urandom());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b1;
      data    = 9'($urandom());
      repeat (3) @(negedge clk_pixel);
      checks++;
      if ({header, sub3, sub2, sub1, sub0, ecc_error, packet_valid} !== '0) begin
         errors++;
         $display("FAIL reset_state: got hdr=%h ecc=%b pv=%b, expected all zero", header, ecc_error, packet_valid);
      end
      reset_n = 1'b1;
      enable  = 1'b0;
      idle(2);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL reset_pulse: got %0d pulses, expected 0", obs_q.size());
      end
      obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_zero_packet();
      logic [W-1:0] got;
      int c0, gc;
      load(24'd0, 56'd0, 56'd0, 56'd0, 56'd0);
      send_symbols(32);
      c0 = cycle;
      idle(3);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL zero_count: got %0d pulses, expected 1", obs_q.size());
      end else begin
         got = obs_q.pop_front();
         gc  = obs_cyc_q.pop_front();
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL zero_packet: got %h, expected 0", got);
         end
         checks++;
         if (gc != c0 + 1) begin
            errors++;
            $display("FAIL zero_latency: pulse at cycle %0d, expected %0d", gc, c0 + 1);
         end
      end
      obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic load_known();
      load(24'h0A0184, 56'h00112233445566, 56'hFEDCBA98765432, 56'h0F0F0F0F0F0F0F, 56'h80000000000001);
   endtask

   task automatic test_known_and_corrupt();
      logic [W-1:0] got, exp;
      logic [4:0]   ecc_exp [3];
`ifdef DATA_ISLAND_RX_ECC_EN
      ecc_exp[0] = 5'b00000; ecc_exp[1] = 5'b00100; ecc_exp[2] = 5'b10000;
`else
      ecc_exp[0] = 5'b00000; ecc_exp[1] = 5'b00000; ecc_exp[2] = 5'b00000;
`endif
      for (int t = 0; t < 3; t++) begin
         load_known();
         if (t == 1) sbits[2][17] = ~sbits[2][17];
         if (t == 2) hbits[27]    = ~hbits[27];
         exp = expected();
         send_symbols(32);
         idle(3);
         checks++;
         if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL known_count[%0d]: got %0d pulses, expected 1", t, obs_q.size());
         end else begin
            got = obs_q.pop_front();
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL known_packet[%0d]: got %h expected %h", t, got, exp);
            end
            checks++;
            if (got[4:0] !== ecc_exp[t]) begin
               errors++;
               $display("FAIL known_ecc[%0d]: got %b expected %b", t, got[4:0], ecc_exp[t]);
            end
         end
         obs_q.delete(); obs_cyc_q.delete();
      end
   endtask

   task automatic test_abort();
      logic [W-1:0] got, exp;
      load_random();
      send_symbols(15);
      idle(3);
      load_random();
      exp = expected();
      send_symbols(32);
      idle(3);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL abort_count: got %0d pulses, expected 1", obs_q.size());
      end else begin
         got = obs_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL abort_packet: got %h expected %h", got, exp);
         end
      end
      obs_q.delete(); obs_cyc_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] got, exp;
      for (int p = 0; p < 3; p++) begin
         load_random();
         exp_q.push_back(expected());
         send_symbols(32);
      end
      idle(3);
      checks++;
      if (obs_q.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses, expected 3", obs_q.size());
      end else begin
         for (int p = 1; p < 3; p++) begin
            checks++;
            if (obs_cyc_q[p] - obs_cyc_q[p-1] != 32) begin
               errors++;
               $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 32", p, obs_cyc_q[p] - obs_cyc_q[p-1]);
            end
         end
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL b2b_packet: got %h expected %h", got, exp);
         end
      end
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_packet();
      logic [W-1:0] got, exp;
      load_random();
      exp_q.push_back(expected());
      send_symbols(32);
      load_random();
      send_symbols(10);
      @(negedge clk_pixel);
      reset_n = 1'b0;
      data    = 9'($urandom());
      repeat (2) @(negedge clk_pixel);
      checks++;
      if ({header, sub3, sub2, sub1, sub0, ecc_error, packet_valid} !== '0) begin
         errors++;
         $display("FAIL midreset_state: got hdr=%h ecc=%b pv=%b, expected all zero", header, ecc_error, packet_valid);
      end
      reset_n = 1'b1;
      enable  = 1'b0;
      load_random();
      exp_q.push_back(expected());
      send_symbols(32);
      idle(3);
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL midreset_count: got %0d pulses, expected 2", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL midreset_packet: got %h expected %h", got, exp);
         end
      end
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic [W-1:0] got, exp;
      int idx;
      for (int p = 0; p < 8; p++) begin
         load_random();
         case ($urandom_range(0, 2))
            1: begin idx = $urandom_range(0, 31); hbits[idx] = ~hbits[idx]; end
            2: begin idx = $urandom_range(0, 63); sbits[p % 4][idx] = ~sbits[p % 4][idx]; end
            default: ;
         endcase
         exp_q.push_back(expected());
         send_symbols(32);
         idle($urandom_range(0, 2));
      end
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random_packet: got %h expected %h", got, exp);
         end
      end
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      data    = 9'd0;
      test_reset();
      test_zero_packet();
      test_known_and_corrupt();
      test_abort();
      test_back_to_back();
      test_reset_mid_packet();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
